// File: rtl/cpu_datapath_pkg.sv
// cpu_defs: shared definitions for the CPU datapath and its control FSM.
// Holds the control-word bit positions for tri_reg and general_reg, the
// register codes, and a helper that detects more than one bus driver.
package cpu_defs;

  localparam int DATA_W_DEF = 8;

  // tri_reg bit indices (bits 6:0 drive R0..R6 directly)
  localparam int TRI_G   = 10;
  localparam int TRI_H   = 9;
  localparam int TRI_EXT = 8;
  localparam int TRI_PC  = 7;

  // general_reg bit indices
  localparam int GR_A_EN  = 5;
  localparam int GR_A_TRI = 4;
  localparam int GR_G_EN  = 3;
  localparam int GR_B_EN  = 2;
  localparam int GR_B_TRI = 1;
  localparam int GR_H_EN  = 0;

  // Register codes; en_reg bit index equals the code
  typedef enum logic [2:0] {
    REG_R0 = 3'd0,
    REG_R1 = 3'd1,
    REG_R2 = 3'd2,
    REG_R3 = 3'd3,
    REG_R4 = 3'd4,
    REG_R5 = 3'd5,
    REG_R6 = 3'd6,
    REG_PC = 3'd7
  } reg_code_e;

  localparam int NUM_SRC = 13;

  // True when two or more source-enable bits are set: clearing the lowest
  // set bit leaves something behind only if a second bit was set.
  function automatic logic multi_driver(input logic [NUM_SRC-1:0] v);
    return ((v & (v - 13'd1)) != 13'd0);
  endfunction

endpackage

// File: rtl/cpu_datapath_dp_reg.sv
// dp_reg: DATA_W-bit datapath register.
// Ports: i_clk (rising edge), i_rst (async active-low), i_clr (sync clear,
// wins over load), i_ld (sync load enable), i_d (load data), o_q (contents).
module dp_reg #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_ld,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  // Storage with clear-over-load priority
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_q <= {DATA_W{1'b0}};
    end else if (i_clr) begin
      r_q <= {DATA_W{1'b0}};
    end else if (i_ld) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: shared-bus register/ALU datapath driven by one-hot control
// words from the control FSM.
// Ports:
//   i_clk, i_rst (async active-low)
//   i_en_reg[7:0]      bus-load enables, bit i = Ri, bit7 = PC
//   i_tri_reg[10:0]    bus drivers: G, H, data_in, PC, R6..R0
//   i_general_reg[5:0] {a_en, a_tri, g_en, b_en, b_tri, h_en}
//   i_done             instruction complete (PC increment)
//   i_addclr/i_xorclr  clear A / B at end of cycle
//   i_data_in          external load data
//   o_bus              combinational bus value
//   o_pc, o_carry, o_zero, o_bus_err  registered status/outputs
module cpu_datapath
  import cpu_defs::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_en_reg,
  input  logic [10:0]       i_tri_reg,
  input  logic [5:0]        i_general_reg,
  input  logic              i_done,
  input  logic              i_addclr,
  input  logic              i_xorclr,
  input  logic [DATA_W-1:0] i_data_in,
  output logic [DATA_W-1:0] o_bus,
  output logic [DATA_W-1:0] o_pc,
  output logic              o_carry,
  output logic              o_zero,
  output logic              o_bus_err
);

  logic [DATA_W-1:0] w_rq [7];
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_bus;
  logic [DATA_W:0]   w_sum;
  logic [NUM_SRC-1:0] w_src;
  logic              w_multi;

  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_g;
  logic [DATA_W-1:0] r_h;
  logic              r_carry;
  logic              r_zero;
  logic              r_bus_err;

  // General registers R0..R6 never clear synchronously
  for (genvar gi = 0; gi < 7; gi++) begin : g_regs
    dp_reg #(.DATA_W(DATA_W)) u_r (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (1'b0),
      .i_ld  (i_en_reg[gi]),
      .i_d   (w_bus),
      .o_q   (w_rq[gi])
    );
  end

  dp_reg #(.DATA_W(DATA_W)) u_a (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_addclr),
    .i_ld  (i_general_reg[GR_A_EN]),
    .i_d   (w_bus),
    .o_q   (w_a)
  );

  dp_reg #(.DATA_W(DATA_W)) u_b (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_xorclr),
    .i_ld  (i_general_reg[GR_B_EN]),
    .i_d   (w_bus),
    .o_q   (w_b)
  );

  assign w_src   = {i_tri_reg, i_general_reg[GR_A_TRI], i_general_reg[GR_B_TRI]};
  assign w_multi = multi_driver(w_src);

  // Bus resolution: wired-OR of every enabled source, 0 when idle
  always_comb begin
    w_bus = ({DATA_W{i_tri_reg[TRI_G]}}              & r_g)
          | ({DATA_W{i_tri_reg[TRI_H]}}              & r_h)
          | ({DATA_W{i_tri_reg[TRI_EXT]}}            & i_data_in)
          | ({DATA_W{i_tri_reg[TRI_PC]}}             & r_pc)
          | ({DATA_W{i_general_reg[GR_A_TRI]}}       & w_a)
          | ({DATA_W{i_general_reg[GR_B_TRI]}}       & w_b);
    for (int i = 0; i < 7; i++) begin
      w_bus = w_bus | ({DATA_W{i_tri_reg[i]}} & w_rq[i]);
    end
  end

  // Adder uses A before any same-edge clear, so ADD2 (g_en + addclr) works
  assign w_sum = {1'b0, w_a} + {1'b0, w_bus};

  // G, carry and zero: updated together only on g_en
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_g     <= {DATA_W{1'b0}};
      r_carry <= 1'b0;
      r_zero  <= 1'b1;
    end else if (i_general_reg[GR_G_EN]) begin
      r_g     <= w_sum[DATA_W-1:0];
      r_carry <= w_sum[DATA_W];
      r_zero  <= (w_sum[DATA_W-1:0] == {DATA_W{1'b0}});
    end else begin
      r_g     <= r_g;
      r_carry <= r_carry;
      r_zero  <= r_zero;
    end
  end

  // H: XOR of pre-edge B with the bus
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_h <= {DATA_W{1'b0}};
    end else if (i_general_reg[GR_H_EN]) begin
      r_h <= w_b ^ w_bus;
    end else begin
      r_h <= r_h;
    end
  end

  // PC: a bus write (jump) wins over the done increment
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pc <= {DATA_W{1'b0}};
    end else if (i_en_reg[REG_PC]) begin
      r_pc <= w_bus;
    end else if (i_done) begin
      r_pc <= r_pc + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      r_pc <= r_pc;
    end
  end

  // Sticky contention flag, cleared only by reset
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= r_bus_err | w_multi;
    end
  end

  assign o_bus     = w_bus;
  assign o_pc      = r_pc;
  assign o_carry   = r_carry;
  assign o_zero    = r_zero;
  assign o_bus_err = r_bus_err;

endmodule

// File: tb/tb_cpu_datapath.sv
module tb_cpu_datapath;

  logic        clk;
  logic        rst;
  logic [7:0]  en_reg;
  logic [10:0] tri_reg;
  logic [5:0]  general_reg;
  logic        done;
  logic        addclr;
  logic        xorclr;
  logic [7:0]  data_in;
  logic [7:0]  bus;
  logic [7:0]  pc;
  logic        carry;
  logic        zero;
  logic        bus_err;

  int n_cmp;
  int n_fail;

  cpu_datapath #(.DATA_W(8)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en_reg      (en_reg),
    .i_tri_reg     (tri_reg),
    .i_general_reg (general_reg),
    .i_done        (done),
    .i_addclr      (addclr),
    .i_xorclr      (xorclr),
    .i_data_in     (data_in),
    .o_bus         (bus),
    .o_pc          (pc),
    .o_carry       (carry),
    .o_zero        (zero),
    .o_bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  en;
    logic [10:0] tr;
    logic [5:0]  gr;
    logic        dn;
    logic        aclr;
    logic        xclr;
    logic [7:0]  din;
    logic [7:0]  e_bus;
    logic [7:0]  e_pc;
    logic        e_c;
    logic        e_z;
    logic        e_err;
  } vec_t;

  // general_reg bit masks
  localparam logic [5:0] A_EN = 6'b100000, A_TRI = 6'b010000, G_EN = 6'b001000;
  localparam logic [5:0] B_EN = 6'b000100, B_TRI = 6'b000010, H_EN = 6'b000001;
  // tri_reg bit masks
  localparam logic [10:0] T_G = 11'h400, T_H = 11'h200, T_EXT = 11'h100;

  vec_t tbl [24];

  function automatic vec_t mk(input logic [7:0] en, input logic [10:0] tr,
                              input logic [5:0] gr, input logic dn,
                              input logic aclr, input logic xclr,
                              input logic [7:0] din, input logic [7:0] e_bus,
                              input logic [7:0] e_pc, input logic e_c,
                              input logic e_z, input logic e_err);
    vec_t v;
    v.en = en; v.tr = tr; v.gr = gr; v.dn = dn; v.aclr = aclr; v.xclr = xclr;
    v.din = din; v.e_bus = e_bus; v.e_pc = e_pc; v.e_c = e_c; v.e_z = e_z;
    v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    en_reg = v.en; tri_reg = v.tr; general_reg = v.gr; done = v.dn;
    addclr = v.aclr; xorclr = v.xclr; data_in = v.din;
  endtask

  task automatic idle_inputs();
    drive(mk(8'h00, 11'h000, 6'h00, 1'b0, 1'b0, 1'b0, 8'h00,
             8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
  endtask

  // Apply one control word: check bus before the edge, state after it
  task automatic step(input string name, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk({name, ".bus"}, bus, v.e_bus);
    @(posedge clk);
    #1;
    chk({name, ".pc"}, pc, v.e_pc);
    chk({name, ".carry"}, {7'd0, carry}, {7'd0, v.e_c});
    chk({name, ".zero"}, {7'd0, zero}, {7'd0, v.e_z});
    chk({name, ".bus_err"}, {7'd0, bus_err}, {7'd0, v.e_err});
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b0;
    idle_inputs();

    //         en      tri           gr            dn    aclr  xclr  din     bus     pc     c     z     err
    tbl[0]  = mk(8'h04, T_EXT,        6'h00,        1'b1, 1'b0, 1'b0, 8'h5A, 8'h5A, 8'h01, 1'b0, 1'b1, 1'b0);
    tbl[1]  = mk(8'h00, 11'h004,      6'h00,        1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, 8'h01, 1'b0, 1'b1, 1'b0);
    tbl[2]  = mk(8'h02, T_EXT,        6'h00,        1'b0, 1'b0, 1'b0, 8'hF0, 8'hF0, 8'h01, 1'b0, 1'b1, 1'b0);
    tbl[3]  = mk(8'h04, T_EXT,        6'h00,        1'b0, 1'b0, 1'b0, 8'h20, 8'h20, 8'h01, 1'b0, 1'b1, 1'b0);
    tbl[4]  = mk(8'h00, 11'h002,      A_EN,         1'b0, 1'b0, 1'b0, 8'h00, 8'hF0, 8'h01, 1'b0, 1'b1, 1'b0);
    tbl[5]  = mk(8'h00, 11'h004,      G_EN,         1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 8'h01, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(8'h02, T_G,          6'h00,        1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 8'h02, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(8'h00, 11'h000,      A_TRI,        1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(8'h00, 11'h002,      6'h00,        1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 8'h02, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(8'h00, T_EXT,        B_EN,         1'b0, 1'b0, 1'b0, 8'h0F, 8'h0F, 8'h02, 1'b1, 1'b0, 1'b0);
    tbl[10] = mk(8'h10, T_EXT,        6'h00,        1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'h02, 1'b1, 1'b0, 1'b0);
    tbl[11] = mk(8'h00, 11'h010,      H_EN,         1'b0, 1'b0, 1'b1, 8'h00, 8'h3C, 8'h02, 1'b1, 1'b0, 1'b0);
    tbl[12] = mk(8'h20, T_H,          6'h00,        1'b0, 1'b0, 1'b0, 8'h00, 8'h33, 8'h02, 1'b1, 1'b0, 1'b0);
    tbl[13] = mk(8'h00, 11'h020,      6'h00,        1'b0, 1'b0, 1'b0, 8'h00, 8'h33, 8'h02, 1'b1, 1'b0, 1'b0);
    tbl[14] = mk(8'h00, 11'h000,      B_TRI,        1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
    tbl[15] = mk(8'h00, T_EXT,        A_EN,         1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0);
    tbl[16] = mk(8'h00, T_EXT,        G_EN,         1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h02, 1'b1, 1'b1, 1'b0);
    tbl[17] = mk(8'h00, T_EXT,        A_EN,         1'b0, 1'b0, 1'b0, 8'h03, 8'h03, 8'h02, 1'b1, 1'b1, 1'b0);
    tbl[18] = mk(8'h00, T_EXT,        G_EN,         1'b0, 1'b0, 1'b0, 8'h04, 8'h04, 8'h02, 1'b0, 1'b0, 1'b0);
    tbl[19] = mk(8'h00, T_G,          6'h00,        1'b0, 1'b0, 1'b0, 8'h00, 8'h07, 8'h02, 1'b0, 1'b0, 1'b0);
    tbl[20] = mk(8'h00, 11'h000,      A_TRI,        1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
    tbl[21] = mk(8'h41, T_G,          6'h00,        1'b0, 1'b0, 1'b0, 8'h00, 8'h07, 8'h02, 1'b0, 1'b0, 1'b0);
    tbl[22] = mk(8'h00, 11'h001,      6'h00,        1'b0, 1'b0, 1'b0, 8'h00, 8'h07, 8'h02, 1'b0, 1'b0, 1'b0);
    tbl[23] = mk(8'h00, 11'h040,      6'h00,        1'b0, 1'b0, 1'b0, 8'h00, 8'h07, 8'h02, 1'b0, 1'b0, 1'b0);

    // Power-on reset and its values
    repeat (2) @(posedge clk);
    #1;
    chk("por.pc", pc, 8'h00);
    chk("por.zero", {7'd0, zero}, 8'h01);
    chk("por.carry", {7'd0, carry}, 8'h00);
    chk("por.bus_err", {7'd0, bus_err}, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
    end

    // Contention: R1|R2 drive together; flag is sticky
    step("con.ld1", mk(8'h02, T_EXT, 6'h00, 1'b0, 1'b0, 1'b0, 8'h0C, 8'h0C, 8'h02, 1'b0, 1'b0, 1'b0));
    step("con.ld2", mk(8'h04, T_EXT, 6'h00, 1'b0, 1'b0, 1'b0, 8'h30, 8'h30, 8'h02, 1'b0, 1'b0, 1'b0));
    step("con.both", mk(8'h00, 11'h006, 6'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h3C, 8'h02, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 10; i++) begin
      step($sformatf("con.idle%0d", i),
           mk(8'h00, 11'h000, 6'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1));
    end

    // Mid-run async reset with R3=0x77, A=0x12 and a pending ADD
    step("rst.r3", mk(8'h08, T_EXT, 6'h00, 1'b0, 1'b0, 1'b0, 8'h77, 8'h77, 8'h02, 1'b0, 1'b0, 1'b1));
    step("rst.a",  mk(8'h00, T_EXT, A_EN,  1'b0, 1'b0, 1'b0, 8'h12, 8'h12, 8'h02, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    drive(mk(8'h00, T_EXT, G_EN, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
    #2;
    rst = 1'b0;
    #1;
    chk("arst.pc", pc, 8'h00);
    chk("arst.carry", {7'd0, carry}, 8'h00);
    chk("arst.zero", {7'd0, zero}, 8'h01);
    chk("arst.bus_err", {7'd0, bus_err}, 8'h00);
    idle_inputs();
    tri_reg = 11'h408;           // R3 | G: both cleared by reset
    general_reg = A_TRI;
    #1;
    chk("arst.bus", bus, 8'h00);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    step("post.g", mk(8'h00, T_G, 6'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0));

    // PC wrap and jump-over-increment
    step("pc.jff",  mk(8'h80, T_EXT, 6'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0));
    step("pc.wrap", mk(8'h00, 11'h000, 6'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0));
    step("pc.jmp",  mk(8'h80, T_EXT, 6'h00, 1'b1, 1'b0, 1'b0, 8'h40, 8'h40, 8'h40, 1'b0, 1'b1, 1'b0));
    step("pc.rd",   mk(8'h00, 11'h080, 6'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 8'h41, 1'b0, 1'b1, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Bus-based register/ALU datapath that executes the one-hot enable and tristate control words issued by the CPU control FSM.
- Holds R0–R6, PC, adder operand A and result G, and XOR operand B and result H.
- Resolves a single shared data bus and advances PC on instruction completion.
- Sits between the control FSM (control inputs) and instruction memory (PC output) and the external data source (data_in).

Parameters:
- DATA_W, 8, width of bus and of every register.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- en_reg  in  8  bus-load enables, bit i = Ri (i=0..6), bit7 = PC.
- tri_reg  in  11  bus drivers: bit10 G, bit9 H, bit8 data_in, bits7:0 R0..R6, PC (bit7 = PC).
- general_reg  in  6  {a_en, a_tri, g_en, b_en, b_tri, h_en}, bit5..bit0.
- done  in  1  instruction complete; increment PC.
- addclr  in  1  clear A at end of cycle.
- xorclr  in  1  clear B at end of cycle.
- data_in  in  DATA_W  external load data.
- bus  out  DATA_W  combinational bus value (observability).
- pc  out  DATA_W  program counter, registered.
- carry  out  1  registered adder carry-out.
- zero  out  1  registered, 1 when G == 0.
- bus_err  out  1  sticky flag: more than one bus driver seen.

Behaviour:
- Reset:
  - Asserting rst low clears R0–R6, PC, A, G, B, H, carry and bus_err to 0 immediately, without waiting for a clock edge.
  - zero resets to 1.
  - Mid-operation reset discards any partial ADD/XOR.
- Bus (combinational):
  - 13 sources: the 11 tri_reg bits, plus A (a_tri) and B (b_tri).
  - bus = bitwise OR of all enabled sources; 0 when none is enabled.
- Register load: on a rising edge, every Ri with en_reg[i]=1 loads bus. Multiple enables in one cycle are legal.
- A: a_en loads bus.
- B: b_en loads bus.
- G:
  - g_en loads (A + bus) mod 2^DATA_W, using A's pre-edge value.
  - carry = bit DATA_W of the sum.
  - zero = (sum[DATA_W-1:0] == 0).
  - carry and zero update only on g_en.
- H: h_en loads B ^ bus, using B's pre-edge value.
- addclr: A <= 0 on the same edge. This takes priority over a_en. G still uses the old A, so the ADD2 cycle (g_en + addclr) works.
- xorclr: B <= 0, with priority over b_en. H uses the old B.
- PC update:
  - done=1 and en_reg[7]=1: PC <= bus (jump; the write wins).
  - done=1 and en_reg[7]=0: PC <= PC + 1, wrapping from 2^DATA_W−1 to 0.
  - done=0 and en_reg[7]=1: PC <= bus.
- bus_err:
  - Set on the edge that follows any cycle with ≥2 active sources.
  - Cleared only by reset.
  - The datapath still executes that cycle using the OR-ed bus.
- Latency:
  - All register effects are visible on the cycle after the edge.
  - bus has zero latency.
- No handshake and no stalls: every control word is consumed in the cycle it is presented.

Decomposition:
- Shared include/package cpu_defs holds:
  - tri_reg bit indices: TRI_G=10, TRI_H=9, TRI_EXT=8, TRI_PC=7.
  - general_reg bit indices: GR_A_EN=5, GR_A_TRI=4, GR_G_EN=3, GR_B_EN=2, GR_B_TRI=1, GR_H_EN=0.
  - Register codes R0..R6, PC = 0..7.
  - The control FSM uses the same file.
- One natural sub-module: dp_reg, a DATA_W-bit register with async active-low reset, synchronous load enable, and synchronous clear having priority. It is instantiated for R0–R6, A and B. PC, G and H are written inline.

Test Plan (DATA_W=8):
1. Reset: drive rst=0 mid-run with R3=0x77 and A=0x12 → all registers, pc, carry and bus_err read 0 and zero reads 1 before the next clk edge.
2. Load: data_in=0x5A, tri_reg[8]=1, en_reg[2]=1, done=1 for one cycle → R2=0x5A, pc 0x00→0x01.
3. Add sequence: R1=0xF0, R2=0x20.
   - Cycle 1: tri[1], a_en → A=0xF0.
   - Cycle 2: tri[2], g_en, addclr → G=0x10, carry=1, zero=0, A=0x00.
   - Cycle 3: tri[10], en[1], done → R1=0x10, pc+1.
4. XOR: B=0x0F; bus driven 0x3C via R4 with h_en and xorclr → H=0x33, B=0x00. Then tri[9], en[5] → R5=0x33.
5. Conflict: tri_reg[1] and tri_reg[2] together, R1=0x0C, R2=0x30 → bus=0x3C that cycle, bus_err=1 next cycle and it stays 1 through 10 idle cycles until reset.
6. PC boundaries:
   - pc=0xFF, done=1 → pc=0x00.
   - Then done=1, en_reg[7]=1, data_in=0x40 via tri[8] → pc=0x40, not 0x01.
